// File: rtl/sqwave_gen_multi.sv
// Multi-channel square/PWM generator: per-channel period, high time and amplitude, reconfigured at period boundaries.
// Optional macro PHASE_OFFSET_EN adds cfg_phase so a channel's counter starts from a programmed phase.
module sqwave_gen_multi #(
    parameter int NCH = 2,
    parameter int DW  = 8,
    parameter int CW  = 16,
    parameter int CHW = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CHW-1:0]    cfg_ch,
    input  logic [CW-1:0]     cfg_period,
    input  logic [CW-1:0]     cfg_high,
    input  logic [DW-1:0]     cfg_amp,
`ifdef PHASE_OFFSET_EN
    input  logic [CW-1:0]     cfg_phase,
`endif
    output logic [NCH*DW-1:0] op,
    output logic [NCH-1:0]    wrap
);
    // Handshake: a config moves into the single pending slot on a posedge with cfg_valid && cfg_ready;
    // cfg_ready is low exactly while the slot is occupied, and the requester holds its data until then.
    logic           pend_valid;
    logic [CHW-1:0] pend_ch;
    logic [CW-1:0]  pend_period;
    logic [CW-1:0]  pend_high;
    logic [DW-1:0]  pend_amp;
    logic [CW-1:0]  pend_start;
    logic [NCH-1:0] apply;
    logic           accept;
    logic           ch_ok;

    assign cfg_ready = !pend_valid;
    assign accept    = cfg_valid && cfg_ready;
    assign ch_ok     = 32'(cfg_ch) < 32'(NCH);

`ifdef PHASE_OFFSET_EN
    logic [CW-1:0] pend_phase;
    logic [CW-1:0] pend_last;
    assign pend_last  = (pend_period == '0) ? '0 : pend_period - CW'(1);
    assign pend_start = (pend_phase > pend_last) ? pend_last : pend_phase;
`else
    assign pend_start = '0;
`endif

    // Out-of-range channel indices complete the handshake but never occupy the slot.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pend_valid  <= 1'b0;
            pend_ch     <= '0;
            pend_period <= '0;
            pend_high   <= '0;
            pend_amp    <= '0;
`ifdef PHASE_OFFSET_EN
            pend_phase  <= '0;
`endif
        end else begin
            if (|apply) pend_valid <= 1'b0;
            if (accept && ch_ok) begin
                pend_valid  <= 1'b1;
                pend_ch     <= cfg_ch;
                pend_period <= cfg_period;
                pend_high   <= cfg_high;
                pend_amp    <= cfg_amp;
`ifdef PHASE_OFFSET_EN
                pend_phase  <= cfg_phase;
`endif
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [CW-1:0] period_r;
        logic [CW-1:0] high_r;
        logic [DW-1:0] amp_r;
        logic [DW-1:0] op_r;
        logic [CW-1:0] cnt;
        logic [CW-1:0] cur;
        logic [CW-1:0] p_last;
        logic          at_last;

        // A programmed period of 0 behaves as a one-sample period.
        assign p_last   = (period_r == '0) ? '0 : period_r - CW'(1);
        assign at_last  = (cur == p_last);
        assign wrap[i]  = en[i] && at_last;
        assign apply[i] = pend_valid && (pend_ch == CHW'(i)) && (!en[i] || at_last);
        assign op[i*DW +: DW] = op_r;

`ifdef PHASE_OFFSET_EN
        logic          en_q;
        logic [CW-1:0] phase_r;
        logic [CW-1:0] start_cur;
        // On the first enabled clock the counter is treated as already sitting at the phase start.
        assign start_cur = (phase_r > p_last) ? p_last : phase_r;
        assign cur       = (en[i] && !en_q) ? start_cur : cnt;

        always_ff @(posedge clk) begin
            if (!rst) begin
                en_q    <= 1'b0;
                phase_r <= '0;
            end else begin
                en_q <= en[i];
                if (apply[i]) phase_r <= pend_phase;
            end
        end
`else
        assign cur = cnt;
`endif

        always_ff @(posedge clk) begin
            if (!rst) begin
                cnt      <= '0;
                period_r <= CW'(256);
                high_r   <= CW'(128);
                amp_r    <= '1;
                op_r     <= '0;
            end else begin
                if (en[i]) begin
                    op_r <= (cur < high_r) ? amp_r : '0;
                    cnt  <= at_last ? '0 : cur + CW'(1);
                end else begin
                    op_r <= '0;
                    cnt  <= '0;
                end
                // New settings take over only on the wrap clock, so the next period is entirely new.
                if (apply[i]) begin
                    period_r <= pend_period;
                    high_r   <= pend_high;
                    amp_r    <= pend_amp;
                    if (en[i]) cnt <= pend_start;
                end
            end
        end
    end
endmodule

// File: tb/tb_sqwave_gen_multi.sv
// Bench for sqwave_gen_multi: elapsed-time reference model with a config queue, directed sequences and random stimulus.
module tb_sqwave_gen_multi;
    localparam int NCH = 2;
    localparam int DW  = 8;
    localparam int CW  = 16;
    localparam int CHW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    en;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CHW-1:0]    cfg_ch;
    logic [CW-1:0]     cfg_period;
    logic [CW-1:0]     cfg_high;
    logic [DW-1:0]     cfg_amp;
    logic [CW-1:0]     cfg_phase;
    logic [NCH*DW-1:0] op;
    logic [NCH-1:0]    wrap;

    sqwave_gen_multi #(.NCH(NCH), .DW(DW), .CW(CW), .CHW(CHW)) dut (
        .clk(clk), .rst(rst), .en(en),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_period(cfg_period), .cfg_high(cfg_high), .cfg_amp(cfg_amp),
`ifdef PHASE_OFFSET_EN
        .cfg_phase(cfg_phase),
`endif
        .op(op), .wrap(wrap)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [CHW-1:0] ch;
        logic [CW-1:0]  period;
        logic [CW-1:0]  high;
        logic [CW-1:0]  phase;
        logic [DW-1:0]  amp;
    } cfg_t;

    typedef struct {
        int period;
        int high;
        int amp;
        int exp_high;
        int exp_wrap;
    } vec_t;

    // Reference model: a channel's position is (segment start + enabled clocks since then) mod P.
    cfg_t              pend_q[$];
    logic [NCH*DW-1:0] exp_q[$];
    logic [CW-1:0]     m_per[NCH];
    logic [CW-1:0]     m_high[NCH];
    logic [CW-1:0]     m_phase[NCH];
    logic [DW-1:0]     m_amp[NCH];
    bit                m_run[NCH];
    longint            m_seg_start[NCH];
    longint            m_seg_t[NCH];

    logic [NCH-1:0]    last_wrap;
    logic              last_ready;
    logic              last_accept;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic longint p_of(int c);
        return (m_per[c] == '0) ? 64'd1 : longint'(m_per[c]);
    endfunction

    function automatic longint start_of(int c);
`ifdef PHASE_OFFSET_EN
        return (longint'(m_phase[c]) > p_of(c) - 1) ? p_of(c) - 1 : longint'(m_phase[c]);
`else
        return 0;
`endif
    endfunction

    function automatic longint pos_of(int c);
        if (!m_run[c]) return start_of(c);
        return (m_seg_start[c] + m_seg_t[c]) % p_of(c);
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_per[c] = 16'd256; m_high[c] = 16'd128; m_amp[c] = 8'hFF; m_phase[c] = '0;
            m_run[c] = 1'b0; m_seg_start[c] = 0; m_seg_t[c] = 0;
        end
        pend_q.delete();
    endfunction

    // One clock: check wrap/cfg_ready before the edge, advance the model at the edge, check op after it.
    task automatic step();
        logic [NCH-1:0]    w;
        logic [NCH*DW-1:0] e;
        bit                m_acc;
        bit                app[NCH];
        bit                any_app;
        cfg_t              nc;
        #1;
        w = '0;
        for (int c = 0; c < NCH; c++)
            if (en[c] && pos_of(c) == p_of(c) - 1) w[c] = 1'b1;
        check("wrap", 64'(wrap), 64'(w));
        check("cfg_ready", 64'(cfg_ready), 64'(pend_q.size() == 0));
        last_wrap   = wrap;
        last_ready  = cfg_ready;
        last_accept = rst && cfg_valid && cfg_ready;
        m_acc       = rst && cfg_valid && (pend_q.size() == 0);
        @(posedge clk);
        e = '0;
        if (!rst) begin
            model_reset();
        end else begin
            any_app = 1'b0;
            for (int c = 0; c < NCH; c++) begin
                app[c] = (pend_q.size() != 0) && (int'(pend_q[0].ch) == c) && (!en[c] || w[c]);
                if (en[c]) begin
                    if (pos_of(c) < longint'(m_high[c])) e[c*DW +: DW] = m_amp[c];
                    if (!m_run[c]) begin
                        m_run[c] = 1'b1; m_seg_start[c] = start_of(c); m_seg_t[c] = 0;
                    end
                    m_seg_t[c]++;
                end else begin
                    m_run[c] = 1'b0;
                end
            end
            for (int c = 0; c < NCH; c++) begin
                if (app[c]) begin
                    any_app = 1'b1;
                    m_per[c] = pend_q[0].period; m_high[c] = pend_q[0].high;
                    m_amp[c] = pend_q[0].amp;    m_phase[c] = pend_q[0].phase;
                    if (en[c]) begin
                        m_seg_start[c] = start_of(c); m_seg_t[c] = 0;
                    end
                end
            end
            if (any_app) void'(pend_q.pop_front());
            if (m_acc && int'(cfg_ch) < NCH) begin
                nc.ch = cfg_ch; nc.period = cfg_period; nc.high = cfg_high;
                nc.phase = cfg_phase; nc.amp = cfg_amp;
                pend_q.push_back(nc);
            end
        end
        exp_q.push_back(e);
        #1;
        check("op", 64'(op), 64'(exp_q.pop_front()));
        @(negedge clk);
    endtask

    task automatic send_cfg(input int ch, input int per, input int hi, input int amp, input int ph,
                            output int stalls);
        cfg_valid = 1'b1; cfg_ch = CHW'(ch); cfg_period = CW'(per); cfg_high = CW'(hi);
        cfg_amp = DW'(amp); cfg_phase = CW'(ph);
        stalls = 0;
        for (int b = 0; b < 1000; b++) begin
            step();
            if (last_accept) break;
            stalls++;
        end
        if (!last_accept) check("cfg_accept_timeout", 64'd0, 64'd1);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_ready(output int low_cnt);
        low_cnt = 0;
        for (int b = 0; b < 1000; b++) begin
            step();
            if (last_ready) break;
            low_cnt++;
        end
        if (!last_ready) check("ready_timeout", 64'd0, 64'd1);
    endtask

    vec_t vecs[8];
    int   st, cnt_a, cnt_b, cnt_c, cnt_d;

    initial begin
        vecs[0] = '{10,  3, 'h5A,  6,  2};
        vecs[1] = '{10,  0, 'hC3,  0,  2};
        vecs[2] = '{10, 12, 'hA5, 20,  2};
        vecs[3] = '{ 0,  1, 'h3C, 20, 20};
        vecs[4] = '{ 1,  0, 'h11,  0, 20};
        vecs[5] = '{ 4,  2, 'h81, 10,  5};
        vecs[6] = '{ 7,  7, 'hF0, 20,  2};
        vecs[7] = '{ 3,  1, 'h0F,  7,  6};

        rst = 1'b0; en = '0; cfg_valid = 1'b0; cfg_ch = '0;
        cfg_period = '0; cfg_high = '0; cfg_amp = '0; cfg_phase = '0;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("reset_op", 64'(op), 64'd0);
        check("reset_wrap", 64'(wrap), 64'd0);
        check("reset_ready", 64'(cfg_ready), 64'd1);

        // Default waveform on ch0 only.
        en = 2'b01;
        cnt_a = 0; cnt_b = 0; cnt_c = 0; cnt_d = 0;
        for (int k = 0; k < 600; k++) begin
            step();
            if (k < 256 && op[DW-1:0] == 8'hFF) cnt_a++;
            if (last_wrap[0]) cnt_b++;
            if (last_wrap[1]) cnt_c++;
            if (op[2*DW-1:DW] != '0) cnt_d++;
        end
        check("dflt_ch0_high", 64'(cnt_a), 64'd128);
        check("dflt_ch0_wraps", 64'(cnt_b), 64'd2);
        check("dflt_ch1_wraps", 64'(cnt_c), 64'd0);
        check("dflt_ch1_nonzero", 64'(cnt_d), 64'd0);

        // Reconfigure ch0 mid-period: accepted at position 88, applied at position 255.
        send_cfg(0, 10, 3, 'h5A, 0, st);
        wait_ready(cnt_a);
        check("cfg_ready_low_clocks", 64'(cnt_a), 64'd167);
        check("new_first_sample", 64'(op[DW-1:0]), 64'h5A);
        cnt_b = (op[DW-1:0] == 8'h5A) ? 1 : 0;
        for (int k = 1; k < 20; k++) begin
            step();
            if (op[DW-1:0] == 8'h5A) cnt_b++;
        end
        check("new_high_count", 64'(cnt_b), 64'd6);

        // Boundary configurations on the idle channel, each run for 20 enabled clocks.
        for (int v = 0; v < 8; v++) begin
            send_cfg(1, vecs[v].period, vecs[v].high, vecs[v].amp, 0, st);
            step();
            en = 2'b11;
            cnt_a = 0; cnt_b = 0;
            for (int k = 0; k < 20; k++) begin
                step();
                if (op[2*DW-1:DW] == DW'(vecs[v].amp)) cnt_a++;
                if (last_wrap[1]) cnt_b++;
            end
            en = 2'b01;
            check($sformatf("vec%0d_high", v), 64'(cnt_a), 64'(vecs[v].exp_high));
            check($sformatf("vec%0d_wrap", v), 64'(cnt_b), 64'(vecs[v].exp_wrap));
        end

        // Back-to-back requests: the second stalls until the first applies.
        send_cfg(0, 6, 2, 'h33, 0, st);
        send_cfg(0, 5, 1, 'h77, 0, st);
        check("second_stalled", 64'(st > 0), 64'd1);
        wait_ready(cnt_a);
        cnt_b = (op[DW-1:0] == 8'h77) ? 1 : 0;
        for (int k = 1; k < 10; k++) begin
            step();
            if (op[DW-1:0] == 8'h77) cnt_b++;
        end
        check("second_high_count", 64'(cnt_b), 64'd2);
        send_cfg(3, 9, 9, 'hEE, 0, st);
        step();
        check("drop_ready", 64'(last_ready), 64'd1);
        for (int k = 0; k < 20; k++) step();

        // Reset with a pending config.
        send_cfg(0, 200, 50, 'h44, 0, st);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("rst_op", 64'(op), 64'd0);
        check("rst_ready", 64'(cfg_ready), 64'd1);
        cnt_a = 0;
        for (int k = 0; k < 256; k++) begin
            step();
            if (op[DW-1:0] == 8'hFF) cnt_a++;
        end
        check("rst_dflt_high", 64'(cnt_a), 64'd128);

`ifdef PHASE_OFFSET_EN
        // Quadrature: ch1 starts two positions ahead of ch0.
        en = '0;
        send_cfg(0, 8, 4, 'hAA, 0, st);
        send_cfg(1, 8, 4, 'hAA, 2, st);
        step();
        en = 2'b11;
        cnt_a = -1; cnt_b = -1;
        for (int t = 0; t < 16; t++) begin
            step();
            check("quad_ch0", 64'(op[DW-1:0]), (t % 8 < 4) ? 64'hAA : 64'h0);
            check("quad_ch1", 64'(op[2*DW-1:DW]), ((t + 2) % 8 < 4) ? 64'hAA : 64'h0);
            if (last_wrap[0] && cnt_a < 0) cnt_a = t;
            if (last_wrap[1] && cnt_b < 0) cnt_b = t;
        end
        check("quad_wrap0_first", 64'(cnt_a), 64'd7);
        check("quad_wrap1_first", 64'(cnt_b), 64'd5);
`endif

        // Random traffic against the model; valid data is held until accepted.
        for (int k = 0; k < 3000; k++) begin
            if (!cfg_valid || last_accept) begin
                cfg_valid  = ($urandom_range(0, 3) == 0);
                cfg_ch     = CHW'($urandom_range(0, 3));
                cfg_period = CW'($urandom_range(0, 12));
                cfg_high   = CW'($urandom_range(0, 14));
                cfg_amp    = DW'($urandom_range(0, 255));
                cfg_phase  = CW'($urandom_range(0, 12));
            end
            if ($urandom_range(0, 7) == 0) en = NCH'($urandom_range(0, 3));
            rst = ($urandom_range(0, 299) != 0);
            step();
        end
        rst = 1'b1; cfg_valid = 1'b0;
        for (int k = 0; k < 20; k++) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
